// File: rtl/comp_serial_nbit.sv
// Bit-serial unsigned magnitude comparator with a start/done handshake.
// It compares the operands MSB first, one bit per clock, and stops at the
// first bit where they differ. All outputs are registered.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_start; the gt/lt/eq flags hold the last result
// CMP     | comparing the operand MSBs, shifting left while they match
// DONE    | one-cycle o_done pulse; the result flags are valid
module comp_serial_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_gt,
    output logic             o_lt,
    output logic             o_eq
);

    // A single-bit operand still needs one counter bit, which holds 0.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;

    logic w_msb_a;
    logic w_msb_b;
    logic w_last;

    // The bit under comparison always sits at the top of the shift registers.
    assign w_msb_a = r_sa[WIDTH-1];
    assign w_msb_b = r_sb[WIDTH-1];
    assign w_last  = (r_cnt == '0);

    // Sequencer: capture the operands, walk the bits, and register the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_sa    <= i_a;
                        r_sb    <= i_b;
                        r_cnt   <= CNT_LOAD;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_eq    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (w_msb_a && !w_msb_b) begin
                        r_gt    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (!w_msb_a && w_msb_b) begin
                        r_lt    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_last) begin
                        r_eq    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_sa  <= r_sa << 1;
                        r_sb  <= r_sb << 1;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    // i_start is ignored here. The earliest new accept is in the
                    // next IDLE cycle.
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_gt   = r_gt;
    assign o_lt   = r_lt;
    assign o_eq   = r_eq;

endmodule

// File: tb/tb_comp_serial_nbit.sv
// Directed bench for comp_serial_nbit. When a comparison is issued, its
// expected result and latency go into a queue. They are popped and checked
// when o_done fires.
module tb_comp_serial_nbit;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic             o_gt;
    logic             o_lt;
    logic             o_eq;

    typedef struct {
        logic [2:0] flags;   // {gt, lt, eq}
        int         lat;     // cycles from the accept cycle S to the done cycle
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    comp_serial_nbit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_gt    (o_gt),
        .o_lt    (o_lt),
        .o_eq    (o_eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the result flags and the done latency S+(WIDTH-p)+1.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input string tag);
        exp_t e;
        int   p;
        p = -1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (p < 0 && a[i] != b[i]) p = i;
        end
        if (p < 0) p = 0;
        e.flags = {(a > b), (a < b), (a == b)};
        e.lat   = WIDTH - p + 1;
        e.tag   = tag;
        return e;
    endfunction

    // Drive one request on the negedge before the accept edge. On return the
    // bench is 1 ns into cycle S+1.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input string tag, input bit hold);
        @(negedge clk);
        i_start = 1'b1;
        i_a     = a;
        i_b     = b;
        sb_q.push_back(model(a, b, tag));
        @(posedge clk);
        #1;
        if (!hold) i_start = 1'b0;
    endtask

    // Sample at each negedge after the accept edge until o_done or timeout.
    // k_start counts the negedges that the caller has already used.
    task automatic wait_done(input int k_start, input bit toggle);
        bit   found;
        exp_t e;
        found = 1'b0;
        for (int k = k_start + 1; k <= k_start + 4 * WIDTH && !found; k++) begin
            @(negedge clk);
            if (o_busy && o_done) check("busy_and_done", 32'(1), 32'(0));
            if (o_done) begin
                found = 1'b1;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(1), 32'(0));
                end else begin
                    e = sb_q.pop_front();
                    check({e.tag, "_lat"},   32'(k), 32'(e.lat));
                    check({e.tag, "_flags"}, 32'({o_gt, o_lt, o_eq}), 32'(e.flags));
                    check({e.tag, "_busy_at_done"}, 32'(o_busy), 32'(0));
                end
            end else if (o_busy !== 1'b1 || {o_gt, o_lt, o_eq} !== 3'b000) begin
                check("busy_phase", 32'({o_busy, o_gt, o_lt, o_eq}), 32'(4'b1000));
            end
            if (toggle) begin
                i_a = WIDTH'($urandom);
                i_b = WIDTH'($urandom);
            end
        end
        if (!found) begin
            check("done_timeout", 32'(0), 32'(1));
            void'(sb_q.pop_front());
        end
    endtask

    function automatic logic [4:0] outs();
        return {o_busy, o_done, o_gt, o_lt, o_eq};
    endfunction

    initial begin
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_a     = '0;
        i_b     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: every output stays low.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_idle", 32'(outs()), 32'(0));
        end

        // Equal operands use the full latency, and eq holds while idle.
        issue(8'hA5, 8'hA5, "eq_a5", 1'b0);
        wait_done(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("eq_hold", 32'(outs()), 32'(5'b00001));
        end

        // The MSB differs, so this is the best case.
        issue(8'h80, 8'h7F, "gt_msb", 1'b0);
        wait_done(0, 1'b0);

        // The first difference is at bit 3.
        issue(8'h34, 8'h3C, "lt_bit3", 1'b0);
        wait_done(0, 1'b0);

        // Only the LSB differs. i_start stays high, and a/b toggle while busy.
        issue(8'h12, 8'h13, "lt_lsb_hold", 1'b1);
        wait_done(0, 1'b1);
        @(negedge clk);   // S+10: back in IDLE with i_start still high
        check("hold_s10", 32'(outs()), 32'(5'b00010));
        i_a = 8'h80;
        i_b = 8'h00;
        sb_q.push_back(model(8'h80, 8'h00, "reaccept"));
        @(negedge clk);   // S+11: the re-accept happened and the flags are cleared
        check("hold_s11", 32'(outs()), 32'(5'b10000));
        i_start = 1'b0;
        wait_done(1, 1'b0);

        // 0x00 vs 0xFF ends at S+2, then an async reset lands at S+3.
        issue(8'h00, 8'hFF, "lt_ff", 1'b0);
        wait_done(0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_after_done", 32'(outs()), 32'(0));

        @(negedge clk);
        rst_n = 1'b1;

        // An async reset in the middle of CMP aborts the compare with no done pulse.
        @(negedge clk);
        i_start = 1'b1;
        i_a     = 8'h00;
        i_b     = 8'h01;
        @(posedge clk);
        #1 i_start = 1'b0;
        repeat (2) @(negedge clk);
        check("midcmp_busy", 32'(outs()), 32'(5'b10000));
        #2 rst_n = 1'b0;
        #1 check("midcmp_rst", 32'(outs()), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold", 32'(outs()), 32'(0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(outs()), 32'(0));
        end

        // After reset, a compare that differs only in the LSB finishes at S+9.
        issue(8'h01, 8'h00, "gt_after_rst", 1'b0);
        wait_done(0, 1'b0);

        // A short randomized sweep checked against the model.
        for (int i = 0; i < 8; i++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), "rand", 1'b0);
            wait_done(0, 1'b0);
        end

        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
